// File: rtl/adder_arbiter.sv
// Credit-based front end that shares one external CREDITS-stage adder between two requesters.
// Build macro ARB_FIXED_PRIORITY_EN selects fixed priority (requester 0 wins); default is round-robin.
module adder_arbiter #(
  parameter int CREDITS = 4,
  parameter int TAGW    = 1,
  localparam int CNTW   = $clog2(CREDITS + 1),
  localparam int PTRW   = (CREDITS > 1) ? $clog2(CREDITS) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req0_valid,
  output logic               req0_allow,
  input  logic [31:0]        req0_data1,
  input  logic [31:0]        req0_data2,
  input  logic               req0_cin,
  input  logic               req1_valid,
  output logic               req1_allow,
  input  logic [31:0]        req1_data1,
  input  logic [31:0]        req1_data2,
  input  logic               req1_cin,
  output logic               rsp0_valid,
  input  logic               rsp0_ready,
  output logic [31:0]        rsp0_res,
  output logic               rsp0_cout,
  output logic               rsp1_valid,
  input  logic               rsp1_ready,
  output logic [31:0]        rsp1_res,
  output logic               rsp1_cout,
  output logic [CREDITS-1:0] add_rst,
  output logic [CREDITS-1:0] add_stop,
  output logic               add_valid_in,
  output logic [31:0]        add_data1,
  output logic [31:0]        add_data2,
  output logic               add_cin,
  output logic               add_out_allow,
  input  logic               add_valid_out,
  input  logic [31:0]        add_res,
  input  logic               add_cout,
  output logic [CNTW-1:0]    inflight
);

  logic [1:0]      req_valid;
  logic [1:0]      rsp_ready;
  logic [1:0]      grant;
  logic [1:0]      allow;
  logic [1:0]      issue_v;
  logic [1:0]      rsp_valid;
  logic            issue_ok;
  logic            issue;
  logic            retire;
  logic            win_idx;
  logic            rsp_live;
  logic [CNTW-1:0] inflight_reg;
  logic [CNTW-1:0] inflight_next;
  logic [PTRW-1:0] wr_ptr_reg;
  logic [PTRW-1:0] wr_ptr_next;
  logic [PTRW-1:0] rd_ptr_reg;
  logic [PTRW-1:0] rd_ptr_next;
  logic [TAGW-1:0] tag_mem [CREDITS];
  logic [TAGW-1:0] head_tag;

  assign req_valid = {req1_valid, req0_valid};
  assign rsp_ready = {rsp1_ready, rsp0_ready};
  assign add_stop  = '1;
  assign add_rst   = {CREDITS{rst}};

  // A retire frees a credit in the same cycle, so a full pipeline keeps streaming.
  assign issue_ok = rst && ((inflight_reg < CNTW'(CREDITS)) || retire);

`ifdef ARB_FIXED_PRIORITY_EN
  always_comb begin
    grant = 2'b00;
    if (req_valid[0]) begin
      grant = 2'b01;
    end else if (req_valid[1]) begin
      grant = 2'b10;
    end
  end
`else
  // last_grant_reg = 1 means requester 1 was served last, so requester 0 wins the next tie.
  logic last_grant_reg;
  logic last_grant_next;

  always_comb begin
    grant = 2'b00;
    if (req_valid[0] && (!req_valid[1] || last_grant_reg)) begin
      grant = 2'b01;
    end else if (req_valid[1]) begin
      grant = 2'b10;
    end
  end

  always_comb begin
    last_grant_next = last_grant_reg;
    if (issue) begin
      last_grant_next = win_idx;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      last_grant_reg <= 1'b1;
    end else begin
      last_grant_reg <= last_grant_next;
    end
  end
`endif

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_port
      assign allow[gi]     = grant[gi] && issue_ok;
      assign issue_v[gi]   = req_valid[gi] && allow[gi];
      assign rsp_valid[gi] = rsp_live && (head_tag == TAGW'(gi));
    end
  endgenerate

  assign issue   = |issue_v;
  assign win_idx = grant[1];

  assign req0_allow   = allow[0];
  assign req1_allow   = allow[1];
  assign add_valid_in = issue;
  assign add_data1    = win_idx ? req1_data1 : req0_data1;
  assign add_data2    = win_idx ? req1_data2 : req0_data2;
  assign add_cin      = win_idx ? req1_cin   : req0_cin;

  // The oldest outstanding tag decides which requester the adder output belongs to.
  assign head_tag      = tag_mem[rd_ptr_reg];
  assign rsp_live      = rst && add_valid_out && (inflight_reg != '0);
  assign add_out_allow = rsp_ready[head_tag[0]];
  assign retire        = rsp_live && add_out_allow;

  assign rsp0_valid = rsp_valid[0];
  assign rsp1_valid = rsp_valid[1];
  assign rsp0_res   = add_res;
  assign rsp1_res   = add_res;
  assign rsp0_cout  = add_cout;
  assign rsp1_cout  = add_cout;
  assign inflight   = inflight_reg;

  function automatic logic [PTRW-1:0] ptr_inc(input logic [PTRW-1:0] p);
    return (p == PTRW'(CREDITS - 1)) ? '0 : p + PTRW'(1);
  endfunction

  always_comb begin
    inflight_next = inflight_reg;
    wr_ptr_next   = wr_ptr_reg;
    rd_ptr_next   = rd_ptr_reg;
    if (issue) begin
      wr_ptr_next = ptr_inc(wr_ptr_reg);
    end
    if (retire) begin
      rd_ptr_next = ptr_inc(rd_ptr_reg);
    end
    if (issue && !retire) begin
      inflight_next = inflight_reg + CNTW'(1);
    end else if (retire && !issue) begin
      inflight_next = inflight_reg - CNTW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      inflight_reg <= '0;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
    end else begin
      inflight_reg <= inflight_next;
      wr_ptr_reg   <= wr_ptr_next;
      rd_ptr_reg   <= rd_ptr_next;
    end
  end

  always_ff @(posedge clk) begin
    if (issue) begin
      tag_mem[wr_ptr_reg] <= TAGW'(win_idx);
    end
  end

endmodule

// File: tb/tb_adder_arbiter.sv
// Randomized + directed bench for adder_arbiter with a 4-stage adder model and an in-order scoreboard.
`timescale 1ns/1ps
module tb_adder_arbiter;
  localparam int CREDITS = 4;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        req0_valid, req0_allow, req0_cin;
  logic [31:0] req0_data1, req0_data2;
  logic        req1_valid, req1_allow, req1_cin;
  logic [31:0] req1_data1, req1_data2;
  logic        rsp0_valid, rsp0_ready, rsp0_cout;
  logic [31:0] rsp0_res;
  logic        rsp1_valid, rsp1_ready, rsp1_cout;
  logic [31:0] rsp1_res;
  logic [3:0]  add_rst, add_stop;
  logic        add_valid_in, add_cin, add_out_allow;
  logic [31:0] add_data1, add_data2;
  logic        add_valid_out, add_cout;
  logic [31:0] add_res;
  logic [2:0]  inflight;

  adder_arbiter dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_allow(req0_allow), .req0_data1(req0_data1),
    .req0_data2(req0_data2), .req0_cin(req0_cin),
    .req1_valid(req1_valid), .req1_allow(req1_allow), .req1_data1(req1_data1),
    .req1_data2(req1_data2), .req1_cin(req1_cin),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_res(rsp0_res), .rsp0_cout(rsp0_cout),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_res(rsp1_res), .rsp1_cout(rsp1_cout),
    .add_rst(add_rst), .add_stop(add_stop), .add_valid_in(add_valid_in),
    .add_data1(add_data1), .add_data2(add_data2), .add_cin(add_cin),
    .add_out_allow(add_out_allow), .add_valid_out(add_valid_out),
    .add_res(add_res), .add_cout(add_cout), .inflight(inflight)
  );

  // External adder: 4 stages, output stage holds while add_out_allow is low.
  logic        ad_v [4];
  logic [32:0] ad_s [4];
  assign add_valid_out = ad_v[3];
  assign add_res       = ad_s[3][31:0];
  assign add_cout      = ad_s[3][32];

  always @(posedge clk) begin
    logic adv [5];
    adv[4] = add_out_allow;
    for (int i = 3; i >= 0; i--) adv[i] = !ad_v[i] || adv[i+1];
    for (int i = 3; i >= 1; i--) begin
      if (adv[i]) begin
        ad_v[i] <= ad_v[i-1];
        ad_s[i] <= ad_s[i-1];
      end
    end
    if (adv[0]) begin
      ad_v[0] <= add_valid_in;
      ad_s[0] <= {1'b0, add_data1} + {1'b0, add_data2} + 33'(add_cin);
    end
    for (int i = 0; i < 4; i++) if (!add_rst[i]) ad_v[i] <= 1'b0;
  end

  typedef struct { logic [31:0] a; logic [31:0] b; logic c; } op_t;
  typedef struct { logic req; logic [32:0] sum; int cyc; } exp_t;

  op_t  q0[$];
  op_t  q1[$];
  exp_t exp_q[$];
  logic grant_log[$];

  int   n_chk = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   exp_count = 0;
  logic last_w = 1'b1;
  bit   hs0, hs1, lat_check;
  int   gap_pct, rdy0_pct, rdy1_pct;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, expv);
    end
  endtask

  // Reference model: credit count, round-robin choice, in-order result queue.
  always @(negedge clk) begin
    exp_t       e;
    logic [1:0] exp_rv;
    logic [1:0] rdy;
    logic       w, any, iss, ret;
    logic [31:0] a, b;
    logic       c;
    int         cur;
    rdy = {rsp1_ready, rsp0_ready};
    cur = exp_count;
    ret = 1'b0;
    chk("add_stop", 64'(add_stop), 64'hF);
    chk("add_rst", 64'(add_rst), 64'({4{rst}}));
    chk("inflight", 64'(inflight), 64'(cur));
    exp_rv = 2'b00;
    if (rst && ad_v[3]) begin
      chk("result_owner", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) exp_rv[exp_q[0].req] = 1'b1;
    end
    chk("rsp0_valid", 64'(rsp0_valid), 64'(exp_rv[0]));
    chk("rsp1_valid", 64'(rsp1_valid), 64'(exp_rv[1]));
    if (rst && exp_q.size() != 0) chk("add_out_allow", 64'(add_out_allow), 64'(rdy[exp_q[0].req]));
    if (exp_rv != 2'b00) begin
      e = exp_q[0];
      if (e.req) chk("rsp1_result", 64'({rsp1_cout, rsp1_res}), 64'(e.sum));
      else       chk("rsp0_result", 64'({rsp0_cout, rsp0_res}), 64'(e.sum));
      if (rdy[e.req]) begin
        ret = 1'b1;
        if (lat_check) chk("latency", 64'(cyc - e.cyc), 64'd4);
        e = exp_q.pop_front();
      end
    end
    any = rst && ((cur < CREDITS) || ret);
`ifdef ARB_FIXED_PRIORITY_EN
    if (req0_valid && req1_valid) w = 1'b0;
`else
    if (req0_valid && req1_valid) w = ~last_w;
`endif
    else w = req1_valid;
    iss = any && (req0_valid || req1_valid);
    chk("req0_allow", 64'(req0_allow), 64'(iss && !w));
    chk("req1_allow", 64'(req1_allow), 64'(iss && w));
    chk("add_valid_in", 64'(add_valid_in), 64'(iss));
    if (iss) begin
      a = w ? req1_data1 : req0_data1;
      b = w ? req1_data2 : req0_data2;
      c = w ? req1_cin   : req0_cin;
      chk("add_data1", 64'(add_data1), 64'(a));
      chk("add_data2", 64'(add_data2), 64'(b));
      chk("add_cin", 64'(add_cin), 64'(c));
      e.req = w;
      e.sum = 33'(a) + 33'(b) + 33'(c);
      e.cyc = cyc;
      exp_q.push_back(e);
      last_w = w;
    end
    exp_count = cur + (iss ? 1 : 0) - (ret ? 1 : 0);
    hs0 = req0_valid && req0_allow;
    hs1 = req1_valid && req1_allow;
    if (hs0) grant_log.push_back(1'b0);
    else if (hs1) grant_log.push_back(1'b1);
    if (!rst) begin
      exp_q.delete();
      exp_count = 0;
      last_w = 1'b1;
    end
  end

  task automatic step();
    op_t t;
    @(posedge clk);
    #1;
    if (hs0 && q0.size() != 0) t = q0.pop_front();
    if (hs1 && q1.size() != 0) t = q1.pop_front();
    if (q0.size() == 0) req0_valid = 1'b0;
    else if (!req0_valid || hs0) req0_valid = ($urandom_range(99) >= gap_pct);
    if (q1.size() == 0) req1_valid = 1'b0;
    else if (!req1_valid || hs1) req1_valid = ($urandom_range(99) >= gap_pct);
    if (q0.size() != 0) begin req0_data1 = q0[0].a; req0_data2 = q0[0].b; req0_cin = q0[0].c; end
    if (q1.size() != 0) begin req1_data1 = q1[0].a; req1_data2 = q1[0].b; req1_cin = q1[0].c; end
    rsp0_ready = ($urandom_range(99) < rdy0_pct);
    rsp1_ready = ($urandom_range(99) < rdy1_pct);
  endtask

  function automatic op_t mk(input logic [31:0] a, input logic [31:0] b, input logic c);
    op_t o;
    o.a = a; o.b = b; o.c = c;
    return o;
  endfunction

  function automatic op_t rand_op();
    op_t o;
    o.a = ($urandom_range(7) == 0) ? 32'hFFFF_FFFF : $urandom;
    o.b = $urandom;
    o.c = 1'($urandom_range(1));
    return o;
  endfunction

  task automatic do_reset();
    step();
    rst = 1'b0;
    step();
    rst = 1'b1;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    rdy0_pct = 100; rdy1_pct = 100; gap_pct = 0;
    while ((q0.size() != 0 || q1.size() != 0 || exp_q.size() != 0) && n < budget) begin
      step();
      n++;
    end
    chk("drain_done", 64'(n < budget), 64'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    rst = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_data1 = '0; req0_data2 = '0; req0_cin = 1'b0;
    req1_data1 = '0; req1_data2 = '0; req1_cin = 1'b0;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    gap_pct = 0; rdy0_pct = 100; rdy1_pct = 100; lat_check = 1'b1;
    for (int i = 0; i < 4; i++) begin ad_v[i] = 1'b0; ad_s[i] = '0; end
    repeat (3) step();
    @(negedge clk);
    chk("reset_inflight", 64'(inflight), 64'd0);
    chk("reset_allow0", 64'(req0_allow), 64'd0);
    step();
    rst = 1'b1;

    // Single issue: 0xFF + 0x1
    q0.push_back(mk(32'h0000_00FF, 32'h0000_0001, 1'b0));
    found = 1'b0;
    for (int i = 0; i < 12 && !found; i++) begin
      step();
      @(negedge clk);
      if (rsp0_valid) found = 1'b1;
    end
    chk("t1_seen", 64'(found), 64'd1);
    chk("t1_result", 64'({rsp0_cout, rsp0_res}), 64'h100);
    chk("t1_rsp1_quiet", 64'(rsp1_valid), 64'd0);
    drain(50);
    $display("single issue done, checks=%0d", n_chk);

    // Contention
    do_reset();
    grant_log.delete();
    for (int i = 0; i < 6; i++) begin q0.push_back(rand_op()); q1.push_back(rand_op()); end
    drain(100);
    chk("t2_log_len", 64'(grant_log.size() >= 6), 64'd1);
    for (int i = 0; i < 6 && i < grant_log.size(); i++) begin
`ifdef ARB_FIXED_PRIORITY_EN
      chk($sformatf("t2_grant%0d", i), 64'(grant_log[i]), 64'd0);
`else
      chk($sformatf("t2_grant%0d", i), 64'(grant_log[i]), 64'(i % 2));
`endif
    end
    $display("contention done, checks=%0d", n_chk);
    lat_check = 1'b0;

    // Credit full with same-cycle retire and issue
    do_reset();
    rdy0_pct = 0;
    for (int i = 0; i < 5; i++) q0.push_back(rand_op());
    repeat (10) step();
    @(negedge clk);
    chk("t3_inflight_full", 64'(inflight), 64'd4);
    chk("t3_allow_blocked", 64'(req0_allow), 64'd0);
    chk("t3_req_held", 64'(req0_valid), 64'd1);
    rdy0_pct = 100;
    step();
    @(negedge clk);
    chk("t3_retire", 64'(rsp0_valid), 64'd1);
    chk("t3_allow_resume", 64'(req0_allow), 64'd1);
    chk("t3_issue", 64'(add_valid_in), 64'd1);
    step();
    @(negedge clk);
    chk("t3_inflight_hold", 64'(inflight), 64'd4);
    drain(50);
    $display("credit full done, checks=%0d", n_chk);

    // Ordering with stalled head
    do_reset();
    rdy0_pct = 100; rdy1_pct = 0;
    q1.push_back(mk(32'hFFFF_FFFF, 32'h0000_0001, 1'b0));
    step();
    q0.push_back(mk(32'h0000_0002, 32'h0000_0003, 1'b0));
    found = 1'b0;
    for (int i = 0; i < 12 && !found; i++) begin
      step();
      @(negedge clk);
      if (rsp1_valid) found = 1'b1;
    end
    chk("t4_rsp1_seen", 64'(found), 64'd1);
    chk("t4_rsp1_result", 64'({rsp1_cout, rsp1_res}), 64'h1_0000_0000);
    chk("t4_rsp0_blocked", 64'(rsp0_valid), 64'd0);
    for (int i = 0; i < 2; i++) begin
      step();
      @(negedge clk);
      chk("t4_rsp0_blocked", 64'(rsp0_valid), 64'd0);
      chk("t4_rsp1_hold", 64'(rsp1_valid), 64'd1);
    end
    rdy1_pct = 100;
    found = 1'b0;
    for (int i = 0; i < 12 && !found; i++) begin
      step();
      @(negedge clk);
      if (rsp0_valid) found = 1'b1;
    end
    chk("t4_rsp0_seen", 64'(found), 64'd1);
    chk("t4_rsp0_result", 64'({rsp0_cout, rsp0_res}), 64'h5);
    drain(50);
    $display("ordering done, checks=%0d", n_chk);

    // Reset with three operations in flight
    rdy0_pct = 0;
    for (int i = 0; i < 3; i++) q0.push_back(rand_op());
    for (int i = 0; i < 20 && !(exp_count == 3 && q0.size() == 0); i++) step();
    @(negedge clk);
    chk("t5_inflight3", 64'(inflight), 64'd3);
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("t5_add_rst", 64'(add_rst), 64'd0);
    chk("t5_allow", 64'(req0_allow), 64'd0);
    step();
    rst = 1'b1;
    @(negedge clk);
    chk("t5_inflight0", 64'(inflight), 64'd0);
    rdy0_pct = 100;
    for (int i = 0; i < 8; i++) begin
      step();
      @(negedge clk);
      chk("t5_no_rsp0", 64'(rsp0_valid), 64'd0);
      chk("t5_no_rsp1", 64'(rsp1_valid), 64'd0);
    end
    $display("reset mid-flight done, checks=%0d", n_chk);

    // Random traffic: light then heavy back-pressure
    for (int phase = 0; phase < 2; phase++) begin
      gap_pct  = 30;
      rdy0_pct = (phase == 0) ? 75 : 25;
      rdy1_pct = (phase == 0) ? 70 : 30;
      for (int i = 0; i < 1000; i++) begin
        if (q0.size() < 2 && $urandom_range(99) < 50) q0.push_back(rand_op());
        if (q1.size() < 2 && $urandom_range(99) < 50) q1.push_back(rand_op());
        step();
      end
      drain(200);
      $display("random phase %0d done, checks=%0d", phase, n_chk);
    end

    step();
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
